// File: rtl/led_defs_pkg.sv
// Shared mode encodings and width helper for the LED PWM bank.
package led_defs_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_OFF   = 2'b00;
   localparam mode_t MODE_ON    = 2'b01;
   localparam mode_t MODE_BLINK = 2'b10;
   localparam mode_t MODE_PWM   = 2'b11;

   // Counter/index width for n states, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      if (n > 1) w = $clog2(n);
      return w;
   endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared timebase for the LED bank: prescaler, PWM counter, period boundary,
// and either the blink phase or (with LED_BREATHE_EN) the breathe ramp.
module led_pwm_timebase
   import led_defs_pkg::*;
#(
   parameter int unsigned DW            = 8,
   parameter int unsigned DIV           = 12,
   parameter int unsigned BLINK_PERIODS = 1953
) (
   input  logic          clk,
   input  logic          rst,
   output logic [DW-1:0] pwm_cnt,
   output logic          boundary_c,
`ifdef LED_BREATHE_EN
   output logic [DW-1:0] ramp
`else
   output logic          phase
`endif
);

   localparam int unsigned PW = cnt_width(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic [PW-1:0] pre;
   logic          tick;

   // With DIV=1 the prescaler is pinned at 0, so tick stays high.
   assign tick       = (pre == PRE_LAST);
   assign boundary_c = tick && (pwm_cnt == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + DW'(1);
      end
   end

`ifdef LED_BREATHE_EN
   localparam logic [DW-1:0] RAMP_MAX = '1;

   logic          ramp_up;
   logic [DW-1:0] ramp_inc;
   logic [DW-1:0] ramp_dec;

   assign ramp_inc = ramp + DW'(1);
   assign ramp_dec = ramp - DW'(1);

   // Triangle ramp; direction flips on the boundary that lands on an extreme.
   always_ff @(posedge clk) begin
      if (rst) begin
         ramp    <= '0;
         ramp_up <= 1'b1;
      end else if (boundary_c) begin
         if (ramp_up) begin
            ramp <= ramp_inc;
            if (ramp_inc == RAMP_MAX) ramp_up <= 1'b0;
         end else begin
            ramp <= ramp_dec;
            if (ramp_dec == '0) ramp_up <= 1'b1;
         end
      end
   end
`else
   localparam int unsigned BW = cnt_width(BLINK_PERIODS);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

   logic [BW-1:0] blink_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (boundary_c) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end
`endif

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver with off/on/blink/PWM modes and boundary-synchronous
// updates. Define LED_BREATHE_EN to turn mode 10 into a shared breathe ramp.
module led_pwm_bank
   import led_defs_pkg::*;
#(
   parameter int unsigned NLEDS         = 8,
   parameter int unsigned DW            = 8,
   parameter int unsigned DIV           = 12,
   parameter int unsigned BLINK_PERIODS = 1953,
   localparam int unsigned AW           = cnt_width(NLEDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [1:0]       wr_mode,
   input  logic [DW-1:0]    wr_duty,
   output logic             period_end,
   output logic [NLEDS-1:0] led
);

   logic [DW-1:0]    pwm_cnt;
   logic             boundary_c;
`ifdef LED_BREATHE_EN
   logic [DW-1:0]    ramp;
`else
   logic             phase;
`endif

   mode_t            shadow_mode [NLEDS];
   logic [DW-1:0]    shadow_duty [NLEDS];
   mode_t            act_mode    [NLEDS];
   logic [DW-1:0]    act_duty    [NLEDS];
   logic [NLEDS-1:0] level;

   led_pwm_timebase #(
      .DW            (DW),
      .DIV           (DIV),
      .BLINK_PERIODS (BLINK_PERIODS)
   ) u_timebase (
      .clk        (clk),
      .rst        (rst),
      .pwm_cnt    (pwm_cnt),
      .boundary_c (boundary_c),
`ifdef LED_BREATHE_EN
      .ramp       (ramp)
`else
      .phase      (phase)
`endif
   );

   // Shadow registers; addresses with no channel simply never match.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NLEDS; i++) begin
            shadow_mode[i] <= MODE_OFF;
            shadow_duty[i] <= '0;
         end
      end else if (wr_en) begin
         for (int unsigned i = 0; i < NLEDS; i++) begin
            if (wr_addr == AW'(i)) begin
               shadow_mode[i] <= wr_mode;
               shadow_duty[i] <= wr_duty;
            end
         end
      end
   end

   // Active copy takes the pre-edge shadow, so a same-cycle write waits a period.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NLEDS; i++) begin
            act_mode[i] <= MODE_OFF;
            act_duty[i] <= '0;
         end
      end else if (boundary_c) begin
         for (int unsigned i = 0; i < NLEDS; i++) begin
            act_mode[i] <= shadow_mode[i];
            act_duty[i] <= shadow_duty[i];
         end
      end
   end

   always_comb begin
      level = '0;
      for (int unsigned i = 0; i < NLEDS; i++) begin
         case (act_mode[i])
            MODE_OFF:   level[i] = 1'b0;
            MODE_ON:    level[i] = 1'b1;
`ifdef LED_BREATHE_EN
            MODE_BLINK: level[i] = pwm_cnt < ((ramp < act_duty[i]) ? ramp : act_duty[i]);
`else
            MODE_BLINK: level[i] = phase && (pwm_cnt < act_duty[i]);
`endif
            MODE_PWM:   level[i] = pwm_cnt < act_duty[i];
            default:    level[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led        <= '0;
         period_end <= 1'b0;
      end else begin
         led        <= level;
         period_end <= boundary_c;
      end
   end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank: two instances (DIV=1 and DIV=2, DW=4)
// exercising reset, on/off, PWM duty, boundary-synchronous updates and blink.
module tb_led_pwm_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en_a, wr_en_b;
   logic [2:0] wr_addr;
   logic [1:0] wr_mode;
   logic [3:0] wr_duty;
   logic       pe_a, pe_b;
   logic [3:0] led_a;
   logic [4:0] led_b;

   int n_tests = 0;
   int n_fail  = 0;
   int n_lit;
   int k_pe;

   always #5 clk = ~clk;

   led_pwm_bank #(.NLEDS(4), .DW(4), .DIV(1), .BLINK_PERIODS(2)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en_a),
      .wr_addr    (wr_addr[1:0]),
      .wr_mode    (wr_mode),
      .wr_duty    (wr_duty),
      .period_end (pe_a),
      .led        (led_a)
   );

   led_pwm_bank #(.NLEDS(5), .DW(4), .DIV(2), .BLINK_PERIODS(2)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en_b),
      .wr_addr    (wr_addr),
      .wr_mode    (wr_mode),
      .wr_duty    (wr_duty),
      .period_end (pe_b),
      .led        (led_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns on the negedge where period_end is seen high.
   task automatic wait_pe(input bit use_b);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if ((use_b ? pe_b : pe_a) === 1'b1) found = 1'b1;
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $error("FAIL wait_pe: observed no period_end expected one within 200 cycles");
      end
   endtask

   task automatic wr(input bit use_b, input logic [2:0] a, input logic [1:0] m,
                     input logic [3:0] d);
      wr_addr = a;
      wr_mode = m;
      wr_duty = d;
      if (use_b) wr_en_b = 1'b1;
      else       wr_en_a = 1'b1;
      @(negedge clk);
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
   endtask

   task automatic count_lit(input bit use_b, input int ch, input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (use_b ? led_b[ch] : led_a[ch]) n++;
      end
   endtask

   initial begin
      rst     = 1'b1;
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
      wr_addr = '0;
      wr_mode = '0;
      wr_duty = '0;
      repeat (3) @(negedge clk);
      check("init_led_a", 32'(led_a), 32'h0);
      check("init_pe_a",  32'(pe_a),  32'h0);
      check("init_led_b", 32'(led_b), 32'h0);
      rst = 1'b0;

      // On/off with exact boundary+1 latency
      wait_pe(1'b0);
      wr(1'b0, 3'd2, 2'b01, 4'd0);
      wait_pe(1'b0);
      check("on_at_boundary", 32'(led_a), 32'h0);
      @(negedge clk);
      check("on_after_boundary", 32'(led_a), 32'h4);
      wr(1'b0, 3'd2, 2'b00, 4'd0);
      wait_pe(1'b0);
      check("off_at_boundary", 32'(led_a), 32'h4);
      @(negedge clk);
      check("off_after_boundary", 32'(led_a), 32'h0);

      // Mid-run reset while ch2 is lit
      wr(1'b0, 3'd2, 2'b01, 4'd0);
      wait_pe(1'b0);
      wait_pe(1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_led", 32'(led_a), 32'h0);
      check("rst_pe",  32'(pe_a),  32'h0);
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      k_pe = -1;
      for (int k = 1; k <= 40 && k_pe < 0; k++) begin
         @(negedge clk);
         if (pe_a === 1'b1) k_pe = k;
      end
      check("first_pe_after_rst", 32'(k_pe), 32'd16);
      @(negedge clk);
      check("shadow_cleared", 32'(led_a), 32'h0);

      // Back-to-back writes, last wins
      wr(1'b0, 3'd3, 2'b11, 4'd3);
      wr(1'b0, 3'd3, 2'b11, 4'd7);
      wait_pe(1'b0);
      count_lit(1'b0, 3, 16, n_lit);
      check("b2b_duty7", 32'(n_lit), 32'd7);

      // PWM duty on the DIV=2 instance (32-cycle period)
      wait_pe(1'b1);
      wr(1'b1, 3'd0, 2'b11, 4'd5);
      wait_pe(1'b1);
      count_lit(1'b1, 0, 32, n_lit);
      check("pwm_duty5", 32'(n_lit), 32'd10);
      wr(1'b1, 3'd0, 2'b11, 4'd0);
      wait_pe(1'b1);
      count_lit(1'b1, 0, 32, n_lit);
      check("pwm_duty0", 32'(n_lit), 32'd0);
      wr(1'b1, 3'd0, 2'b11, 4'd15);
      wait_pe(1'b1);
      count_lit(1'b1, 0, 32, n_lit);
      check("pwm_duty15", 32'(n_lit), 32'd30);

      // Write landing on the boundary edge waits one more period
      repeat (31) @(negedge clk);
      wr_addr = 3'd0;
      wr_mode = 2'b11;
      wr_duty = 4'd12;
      wr_en_b = 1'b1;
      @(negedge clk);
      wr_en_b = 1'b0;
      check("boundary_write_pe", 32'(pe_b), 32'h1);
      count_lit(1'b1, 0, 32, n_lit);
      check("old_duty_holds", 32'(n_lit), 32'd30);
      count_lit(1'b1, 0, 32, n_lit);
      check("new_duty12", 32'(n_lit), 32'd24);

      // Addresses beyond NLEDS are ignored
      wr(1'b1, 3'd7, 2'b01, 4'd15);
      wr(1'b1, 3'd5, 2'b01, 4'd15);
      wait_pe(1'b1);
      wait_pe(1'b1);
      @(negedge clk);
      check("bad_addr_ignored", 32'(led_b), 32'h01);

      // Blink: 2 periods dark, 2 lit, anchored to a fresh reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wr(1'b0, 3'd0, 2'b10, 4'd15);
      wait_pe(1'b0);
      for (int p = 0; p < 8; p++) begin
         int exp_lit;
         exp_lit = (p % 4 == 1 || p % 4 == 2) ? 15 : 0;
         count_lit(1'b0, 0, 16, n_lit);
         check($sformatf("blink_p%0d", p), 32'(n_lit), 32'(exp_lit));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
